// File: rtl/siso_frame_deser.sv
`default_nettype none
// ============================================================================
// Module   : siso_frame_deser
// Brief    : Serial frame receiver: start bit, LSB-first data, optional even
//            parity, stop bit; presents word, valid/error pulses, frame count.
// Revision : 1.0
// ============================================================================
module siso_frame_deser #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (sin) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shreg_d[bit_cnt_q] = sin;
                if (bit_cnt_q == c_last_bit) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                par_d   = sin;
                state_d = STOP;
            end
            STOP: begin
                // The stop bit always ends the frame; it is never a new start bit.
                if (!sin) begin
                    dout_d       = shreg_q;
                    dout_valid_d = 1'b1;
                    parity_err_d = (PARITY_EN != 0) && ((^shreg_q) ^ par_q);
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end else begin
                    frame_err_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_siso_frame_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_siso_frame_deser
// Brief    : Directed, table-driven bench for siso_frame_deser (DATA_W=8, parity on).
// Revision : 1.0
// ============================================================================
module tb_siso_frame_deser;

    logic       clk;
    logic       rst;
    logic       sin;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_cnt;

    int checks;
    int errors;

    siso_frame_deser #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       fe;
        logic       b;
        logic [7:0] c;
    } vec_t;

    vec_t rows[$];

    function automatic void add(input logic s, input logic [7:0] d, input logic v,
                                input logic pe, input logic fe, input logic b,
                                input logic [7:0] c);
        vec_t r;
        r.s = s; r.d = d; r.v = v; r.pe = pe; r.fe = fe; r.b = b; r.c = c;
        rows.push_back(r);
    endfunction

    // One full frame of rows: outputs hold until the stop edge, then update.
    function automatic void add_frame(input logic [7:0] data, input logic par, input logic stp,
                                      input logic [7:0] old_d, input logic [7:0] new_d,
                                      input logic pe, input logic [7:0] old_c,
                                      input logic [7:0] new_c);
        logic [7:0] dv;
        dv = data;
        add(1'b1, old_d, 1'b0, 1'b0, 1'b0, 1'b1, old_c);
        for (int i = 0; i < 8; i++) add(dv[i], old_d, 1'b0, 1'b0, 1'b0, 1'b1, old_c);
        add(par, old_d, 1'b0, 1'b0, 1'b0, 1'b1, old_c);
        add(stp, new_d, ~stp, pe, stp, 1'b0, new_c);
    endfunction

    task automatic step(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [7:0] d, input logic v,
                             input logic pe, input logic fe, input logic b,
                             input logic [7:0] c);
        checks++;
        if (dout !== d || dout_valid !== v || parity_err !== pe || frame_err !== fe ||
            busy !== b || frame_cnt !== c) begin
            errors++;
            $display("FAIL %s: got dout=%h v=%b pe=%b fe=%b busy=%b cnt=%0d, want dout=%h v=%b pe=%b fe=%b busy=%b cnt=%0d",
                     name, dout, dout_valid, parity_err, frame_err, busy, frame_cnt,
                     d, v, pe, fe, b, c);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < rows.size(); i++) begin
            step(rows[i].s);
            check_now($sformatf("%s[%0d]", tag, i), rows[i].d, rows[i].v, rows[i].pe,
                      rows[i].fe, rows[i].b, rows[i].c);
        end
        rows.delete();
    endtask

    task automatic send_frame(input logic [7:0] data);
        step(1'b1);
        for (int i = 0; i < 8; i++) step(data[i]);
        step(^data);
        step(1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_now("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // Good frame 0xA5, parity-error frame 0x3C, framing-error frame 0x5A
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add_frame(8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'd0, 8'd1);
        add(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        add_frame(8'h3C, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 8'd1, 8'd2);
        add(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        add_frame(8'h5A, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 8'd2, 8'd2);
        add(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        run_table("basic");

        // Back-to-back: second start sampled right after first stop edge
        add_frame(8'h01, 1'b1, 1'b0, 8'h3C, 8'h01, 1'b0, 8'd2, 8'd3);
        add_frame(8'hFE, 1'b1, 1'b0, 8'h01, 8'hFE, 1'b0, 8'd3, 8'd4);
        add(1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        run_table("b2b");

        // Asynchronous reset after four data bits
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check_now("midframe_busy", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_now("reset_held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add_frame(8'hC3, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'd0, 8'd1);
        add(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        run_table("post_reset");

        // Counter wrap over 256 good frames
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check_now("wrap_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i));
            if (i == 254)
                check_now("wrap_255th", 8'd254, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
            if (i == 255)
                check_now("wrap_256th", 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        step(1'b0);
        check_now("wrap_idle", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/siso_frame_deser.md
# siso_frame_deser

Serial-to-parallel frame receiver that sits directly downstream of the SISO shift register and consumes its serial output `sout` on the same clock. It finds a start bit on the serial line and collects `DATA_W` data bits LSB-first. It then checks an optional even-parity bit and a stop bit, and presents the assembled word with a one-cycle valid strobe plus error flags and a good-frame counter.

## Interface
- `DATA_W`, default 8: data bits per frame (legal range 2..16).
- `PARITY_EN`, default 1: 1 means a parity bit follows the data; 0 means no parity bit.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all state immediately.
- `sin` input 1: serial line, one bit per clock, driven by the shift register's `sout`; idle level 0.
- `dout` output DATA_W: last received data word, bit 0 = first data bit received.
- `dout_valid` output 1: one-cycle pulse when a frame with a correct stop bit completes.
- `parity_err` output 1: one-cycle pulse, coincident with `dout_valid`, when the parity check fails.
- `frame_err` output 1: one-cycle pulse when the stop bit is 1.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).
- `frame_cnt` output 8: count of `dout_valid` pulses; wraps from 255 to 0.

## Operation
- Frame on `sin`: start bit (1), then `DATA_W` data bits LSB-first, then parity bit (only if `PARITY_EN`), then stop bit (0).
- Even parity: the data bits plus the parity bit contain an even number of ones.
- State machine (IDLE, DATA, PARITY, STOP):
  - IDLE: `sin`=1 → go to DATA and clear `bit_cnt`. `sin`=0 → stay in IDLE.
  - DATA: write `sin` into `shreg[bit_cnt]` and increment `bit_cnt`. After data bit `DATA_W-1`, go to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: capture `sin` as the received parity bit; go to STOP.
  - STOP, `sin`=0: load `dout` with `shreg` and pulse `dout_valid`. Pulse `parity_err` if (XOR of `shreg`) XOR (received parity) equals 1. Increment `frame_cnt`. Go to IDLE.
  - STOP, `sin`=1: pulse `frame_err`. `dout`, `dout_valid`, `parity_err` and `frame_cnt` are unchanged. Go to IDLE.
- STOP always returns to IDLE. The stop bit is never reinterpreted as a new start bit.
- `bit_cnt` is sized `$clog2(DATA_W)`. It never exceeds `DATA_W-1`.
- With `PARITY_EN`=0, the PARITY state is unreachable and `parity_err` stays 0.
- Reset values: `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `frame_cnt`=0, state = IDLE, `shreg`=0, `bit_cnt`=0.
- Reset asserted mid-frame: the partial frame is discarded with no pulses emitted. After release, the receiver waits in IDLE for a new start bit.

## Timing
- One serial bit is sampled per rising edge. There is no oversampling and no synchronizer, because `sin` is synchronous to `clk`.
- Edge numbering: the start bit is sampled at edge S.
  - Data bits are sampled at edges S+1 .. S+DATA_W.
  - The parity bit is sampled at edge S+DATA_W+1.
  - The stop bit is sampled at edge S+DATA_W+2, or S+DATA_W+1 when `PARITY_EN`=0.
- `dout`, `dout_valid`, `parity_err` and `frame_err` are registered outputs that change at the stop-bit edge. Pulses are high for exactly one cycle.
- `busy` rises at edge S and falls at the stop-bit edge.
- Back-to-back frames: the earliest next start bit is sampled at the edge after the stop-bit edge. Minimum frame spacing is DATA_W+3 clocks with parity, DATA_W+2 without.
- `dout` holds its value between frames. It changes only on a valid stop bit.

## Test plan
Defaults for all scenarios: `DATA_W`=8, `PARITY_EN`=1.
1. Good frame: after reset, drive 0,0,1, then 1,0,1,0,0,1,0,1, then parity 0, stop 0 → `dout`=0xA5 and a one-cycle `dout_valid` 10 edges after the start edge; `parity_err`=0; `frame_cnt`=1.
2. Parity error: frame carrying data 0x3C with parity bit 1 → `dout`=0x3C, with `dout_valid` and `parity_err` pulsing together; `frame_cnt` increments.
3. Framing error: frame carrying data 0x5A, parity 0, stop 1 → `frame_err` pulses; `dout` keeps its previous value; no `dout_valid`; `frame_cnt` unchanged.
4. Back-to-back: frame 0x01 immediately followed by frame 0xFE, with the second start bit sampled at the edge after the first stop edge → two `dout_valid` pulses exactly 11 cycles apart, carrying 0x01 then 0xFE.
5. Reset mid-frame: assert `rst` asynchronously after 4 data bits → all outputs clear immediately; no pulses; a subsequent full frame 0xC3 is received correctly.
6. Counter wrap: send 256 good frames → `frame_cnt` reads 255 after the 255th frame and 0 after the 256th.
